// File: rtl/poly_unload.sv
// poly_unload: streams the contents of the NTT RAM (2^ADDWID words of
// RDWID bits) out on a valid/ready interface, either one RAM word per beat
// or one WID-bit coefficient per beat (4 coefficients per word, LSB first).
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start, coef_mode  begin an unload (IDLE only); coef_mode latched with it
//   busy, done        busy outside IDLE; done pulses for the DONE cycle
//   ram_ra, ram_re    RAM read address / request (data returns next cycle)
//   ram_rdo           RAM read data
//   out_data, out_valid, out_ready, out_last   output stream
module poly_unload #(
  parameter int WID    = 12,
  parameter int RDWID  = 48,
  parameter int ADDWID = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_mode,
  output logic              busy,
  output logic              done,
  output logic [ADDWID-1:0] ram_ra,
  output logic              ram_re,
  input  logic [RDWID-1:0]  ram_rdo,
  output logic [RDWID-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  // Four entries: two would hold steady-state traffic only if the read
  // request could count the same-cycle pop, which the occupancy rule
  // (buffered + in flight < depth) does not allow. Four keeps word mode
  // bubble-free while never dropping a returned word.
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic              r_mode;
  logic [ADDWID-1:0] r_ra;
  logic              r_rd_done;   // all 2^ADDWID reads issued
  logic              r_infl;      // a read was issued last cycle
  logic [RDWID-1:0]  r_buf [DEPTH];
  logic [1:0]        r_wp, r_rp;
  logic [2:0]        r_cnt;
  logic [1:0]        r_idx;       // coefficient index within head word
  logic [ADDWID-1:0] r_wcnt;      // words popped so far

  logic              w_run, w_re, w_valid, w_hs, w_pop, w_last;
  logic [2:0]        w_occ;
  logic [RDWID-1:0]  w_head;
  logic [WID-1:0]    w_coef;

  assign w_run   = (r_state == S_RUN);
  assign w_occ   = r_cnt + {2'b00, r_infl};
  assign w_re    = w_run && !r_rd_done && (w_occ < 3'(DEPTH));
  assign w_valid = w_run && (r_cnt != 3'd0);
  assign w_hs    = w_valid && out_ready;
  // In coefficient mode the head word stays until its 4th coefficient goes.
  assign w_pop   = w_hs && (!r_mode || r_idx == 2'd3);
  assign w_last  = w_valid && (r_wcnt == {ADDWID{1'b1}}) &&
                   (!r_mode || r_idx == 2'd3);
  assign w_head  = r_buf[r_rp];
  assign w_coef  = w_head[r_idx*WID +: WID];

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ram_ra    = r_ra;
  assign ram_re    = w_re;
  assign out_valid = w_valid;
  assign out_last  = w_last;
  // Gated so the bus reads zero whenever nothing is offered (incl. reset).
  assign out_data  = !w_valid ? '0 :
                     r_mode   ? {{(RDWID-WID){1'b0}}, w_coef} : w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_ra      <= '0;
      r_rd_done <= 1'b0;
      r_infl    <= 1'b0;   // drops any read in flight
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wcnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_infl <= w_re;

      case (r_state)
        S_IDLE: if (start) begin
          r_state   <= S_RUN;
          r_mode    <= coef_mode;
          r_ra      <= '0;
          r_rd_done <= 1'b0;
          r_wcnt    <= '0;
          r_idx     <= '0;
        end
        S_RUN:   if (w_hs && w_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Address holds at the top word instead of wrapping.
      if (w_re) begin
        if (r_ra == {ADDWID{1'b1}}) r_rd_done <= 1'b1;
        else                        r_ra      <= r_ra + 1'b1;
      end

      if (r_infl) begin
        r_buf[r_wp] <= ram_rdo;
        r_wp        <= r_wp + 1'b1;
      end

      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_wcnt <= r_wcnt + 1'b1;
      end

      if (w_hs && r_mode) r_idx <= r_idx + 1'b1;

      r_cnt <= r_cnt + {2'b00, r_infl} - {2'b00, w_pop};
    end
  end

endmodule

// File: tb/tb_poly_unload.sv
module tb_poly_unload;
  localparam int WID = 12, RDWID = 48, ADDWID = 5;
  localparam int NW = 1 << ADDWID;
  localparam int DEPTH = 4;   // design's read buffer depth

  logic              clk = 1'b0;
  logic              rst, start, coef_mode, out_ready;
  logic              busy, done, ram_re, out_valid, out_last;
  logic [ADDWID-1:0] ram_ra;
  logic [RDWID-1:0]  ram_rdo, out_data;

  int n_chk = 0, n_fail = 0;
  int pat = 0;

  poly_unload #(.WID(WID), .RDWID(RDWID), .ADDWID(ADDWID)) dut (
    .clk(clk), .rst(rst), .start(start), .coef_mode(coef_mode),
    .busy(busy), .done(done), .ram_ra(ram_ra), .ram_re(ram_re),
    .ram_rdo(ram_rdo), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last));

  always #5 clk = ~clk;

  // pattern 0: all four coefficients = i; pattern 1: coefficient k = i + k*0x100
  function automatic logic [RDWID-1:0] word(input int p, input int i);
    if (p == 0) return {4{12'(i)}};
    return {12'(i + 'h300), 12'(i + 'h200), 12'(i + 'h100), 12'(i)};
  endfunction

  function automatic logic [RDWID-1:0] exp_beat(input logic m, input int p, input int n);
    logic [RDWID-1:0] w;
    if (!m) return word(p, n);
    w = word(p, n >> 2);
    return {36'd0, w[(n % 4)*WID +: WID]};
  endfunction

  initial ram_rdo = '0;
  always @(posedge clk) if (ram_re) ram_rdo <= word(pat, int'(ram_ra));

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_unload(input logic m, input int p, input int rmode,
                            input bit poke, input int nbeats, input int abort_at);
    int n = 0, cyc = 1, issued = 0, popped = 0, exp_addr = 0, first_c = -1;
    int stall_left = 0;
    bit stalled_once = 0, poked = 0, done_seen = 0, prev_stall = 0;
    logic [RDWID-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    @(negedge clk);
    pat = p; coef_mode = m; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b1; start = 1'b1;   // reset must win over start
        return;
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2) == 1;
        default: if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
                 else out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && n == 10 && !poked) begin
        start = 1'b1; coef_mode = !m; poked = 1;
      end else start = 1'b0;
      if (cyc == 1) chk(ram_re && ram_ra == 0, "first_read", {ram_re, 8'(ram_ra)}, 64'h100);
      if (ram_re) begin
        chk(ram_ra == ADDWID'(exp_addr) && exp_addr < NW, "read_addr", 64'(ram_ra), 64'(exp_addr));
        chk(issued - popped < DEPTH, "buf_full_read", 64'(issued - popped), 64'(DEPTH - 1));
        issued++; exp_addr++;
      end
      if (done) begin
        done_seen = 1;
        chk(!out_valid && busy && !ram_re, "done_cycle", {out_valid, busy, ram_re}, 64'b010);
      end else begin
        if (prev_stall)
          chk(out_valid && out_data == prev_data && out_last == prev_last, "stall_stable",
              64'(out_data), 64'(prev_data));
        if (out_valid) begin
          if (first_c < 0) first_c = cyc;
          if (out_ready) begin
            chk(out_data == exp_beat(m, p, n), "beat_data", 64'(out_data), 64'(exp_beat(m, p, n)));
            chk(out_last == (n == nbeats - 1), "beat_last", 64'(out_last), 64'(n == nbeats - 1));
            if (rmode == 0) chk(cyc == 3 + n, "no_bubble", 64'(cyc), 64'(3 + n));
            n++;
            if (!m || n % 4 == 0) popped++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data; prev_last = out_last;
        if (rmode == 2 && n == 5 && !stalled_once) begin stall_left = 10; stalled_once = 1; end
      end
      if (!done_seen) begin @(negedge clk); cyc++; end
    end
    chk(done_seen, "done_timeout", 64'(done_seen), 64'd1);
    chk(n == nbeats, "beat_count", 64'(n), 64'(nbeats));
    chk(exp_addr == NW, "read_count", 64'(exp_addr), 64'(NW));
    chk(first_c == 3, "first_valid_cycle", 64'(first_c), 64'd3);
    if (rmode == 0) chk(cyc == 3 + nbeats, "done_cycle_pos", 64'(cyc), 64'(3 + nbeats));
    if (poke) start = 1'b1;   // during DONE: must be ignored
    @(negedge clk);
    start = 1'b0;
    chk(!busy && !done, "idle_after_done", {busy, done}, 64'd0);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk(!busy && !ram_re && !done, "no_second_unload", {busy, ram_re, done}, 64'd0);
    end
  endtask

  typedef struct {
    logic mode;
    int   pat;
    int   rmode;   // 0 always ready, 1 toggling, 2 random with a 10-cycle stall
    bit   poke;    // start + coef_mode change mid-unload, start during DONE
    int   nbeats;  // expected beat count
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 0, 0, 1'b0, 32};
    vecs[1] = '{1'b1, 0, 0, 1'b0, 128};
    vecs[2] = '{1'b1, 1, 0, 1'b0, 128};
    vecs[3] = '{1'b0, 1, 2, 1'b0, 32};
    vecs[4] = '{1'b1, 1, 1, 1'b0, 128};
    vecs[5] = '{1'b0, 0, 0, 1'b1, 32};
    vecs[6] = '{1'b1, 1, 2, 1'b1, 128};

    rst = 1'b1; start = 1'b0; coef_mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk({busy, done, ram_re, out_valid, out_last} == 5'd0 && ram_ra == 0 && out_data == 0,
        "reset_state", {busy, done, ram_re, out_valid, out_last}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk(!busy, "idle_no_start", 64'(busy), 64'd0);

    for (int v = 0; v < 7; v++)
      run_unload(vecs[v].mode, vecs[v].pat, vecs[v].rmode, vecs[v].poke, vecs[v].nbeats, -1);

    // reset at beat 7 of a word-mode unload, with start asserted alongside
    run_unload(1'b0, 1, 0, 1'b0, 32, 7);
    @(negedge clk);
    chk({busy, done, ram_re, out_valid, out_last} == 5'd0 && ram_ra == 0 && out_data == 0,
        "mid_reset_outputs", {busy, done, ram_re, out_valid, out_last, 8'(ram_ra)}, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk(!busy, "rst_over_start", 64'(busy), 64'd0);
    run_unload(1'b0, 1, 0, 1'b0, 32, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
